// File: rtl/dbuf_pkg.sv
// Shared types and helpers for the dbuf_filt multi-channel deglitch buffer.
package dbuf_pkg;

   typedef enum logic {
      DBUF_STABLE  = 1'b0,
      DBUF_QUALIFY = 1'b1
   } dbuf_state_e;

   localparam int WIDTH_MIN    = 1;
   localparam int WIDTH_MAX    = 32;
   localparam int SYNC_MIN     = 2;
   localparam int SYNC_MAX     = 4;
   localparam int FILT_CNT_MIN = 1;
   localparam int FILT_CNT_MAX = 255;

   // Qualification counter width: max(1, clog2(n)).
   function automatic int cnt_w(input int n);
      int c;
      c = $clog2(n);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/dbuf_filt_chan.sv
// One dbuf_filt channel: synchroniser, stability filter FSM, sticky glitch flag
// and, with DBUF_FILT_EDGE_EN defined, registered rise/fall pulses.
module dbuf_filt_chan
   import dbuf_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   FILT_CNT    = 8,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   input  logic glitch_clr,
   output logic o,
`ifdef DBUF_FILT_EDGE_EN
   output logic rise,
   output logic fall,
`endif
   output logic glitch
);

   localparam int            CW       = cnt_w(FILT_CNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

   logic [SYNC_STAGES-1:0] sync_p0;
   logic                   s;
   dbuf_state_e            state, state_nxt;
   logic [CW-1:0]          cnt, cnt_nxt;
   logic                   o_nxt;
   logic                   gset;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_p0 <= {SYNC_STAGES{RST_VAL}};
      else        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
   end

   assign s = sync_p0[SYNC_STAGES-1];

   // filter stage: s must differ from o for FILT_CNT consecutive edges
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      o_nxt     = o;
      gset      = 1'b0;
      case (state)
         DBUF_STABLE: begin
            if (s != o) begin
               if (FILT_CNT == 1) begin
                  o_nxt = ~o;
               end else begin
                  state_nxt = DBUF_QUALIFY;
                  cnt_nxt   = CW'(1);
               end
            end
         end
         DBUF_QUALIFY: begin
            if (s != o) begin
               if (cnt == CNT_LAST) begin
                  o_nxt     = ~o;
                  cnt_nxt   = '0;
                  state_nxt = DBUF_STABLE;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end else begin
               cnt_nxt   = '0;
               state_nxt = DBUF_STABLE;
               gset      = 1'b1;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = DBUF_STABLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= DBUF_STABLE;
         cnt    <= '0;
         o      <= RST_VAL;
         glitch <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         o      <= o_nxt;
         // a new glitch on the clearing edge takes priority over the clear
         glitch <= gset | (glitch & ~glitch_clr);
      end
   end

`ifdef DBUF_FILT_EDGE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= o_nxt & ~o;
         fall <= ~o_nxt & o;
      end
   end
`endif

endmodule

// File: rtl/dbuf_filt.sv
// dbuf_filt: WIDTH independent synchronise-and-deglitch channels.
// Optional rise/fall edge pulses are built when DBUF_FILT_EDGE_EN is defined.
module dbuf_filt
   import dbuf_pkg::*;
#(
   parameter int   WIDTH       = 4,
   parameter int   SYNC_STAGES = 2,
   parameter int   FILT_CNT    = 8,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic             CLK,
   input  logic             RSTB,
   input  logic             CELV,
   input  logic             CELG,
   input  logic             SUB,
   input  logic [WIDTH-1:0] i,
   output logic [WIDTH-1:0] o,
   output logic [WIDTH-1:0] glitch,
   input  logic             glitch_clr
`ifdef DBUF_FILT_EDGE_EN
   ,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
`endif
);

   // supply pins exist only for netlist compatibility
   logic supply_unused;
   assign supply_unused = ^{CELV, CELG, SUB};

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      dbuf_filt_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_CNT    (FILT_CNT),
         .RST_VAL     (RST_VAL)
      ) u_chan (
         .clk        (CLK),
         .rst_n      (RSTB),
         .d          (i[g]),
         .glitch_clr (glitch_clr),
         .o          (o[g]),
`ifdef DBUF_FILT_EDGE_EN
         .rise       (rise[g]),
         .fall       (fall[g]),
`endif
         .glitch     (glitch[g])
      );
   end

endmodule

// File: tb/tb_dbuf_filt.sv
// Bench for dbuf_filt: window-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed latencies and flag values.
module tb_dbuf_filt;

   localparam int SS = 2;

   logic       CLK = 1'b0;
   logic       RSTB = 1'b0;
   logic       glitch_clr = 1'b0;
   logic [3:0] i0 = 4'h0;
   logic [3:0] i1 = 4'h0;
   logic [3:0] o0, g0, o1, g1;
`ifdef DBUF_FILT_EDGE_EN
   logic [3:0] r0, f0, r1, f1;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 CLK = ~CLK;

   dbuf_filt #(.WIDTH(4), .SYNC_STAGES(2), .FILT_CNT(8), .RST_VAL(1'b0)) dut (
      .CLK(CLK), .RSTB(RSTB), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
      .i(i0), .o(o0), .glitch(g0), .glitch_clr(glitch_clr)
`ifdef DBUF_FILT_EDGE_EN
      , .rise(r0), .fall(f0)
`endif
   );

   dbuf_filt #(.WIDTH(4), .SYNC_STAGES(2), .FILT_CNT(1), .RST_VAL(1'b0)) dut1 (
      .CLK(CLK), .RSTB(RSTB), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
      .i(i1), .o(o1), .glitch(g1), .glitch_clr(glitch_clr)
`ifdef DBUF_FILT_EDGE_EN
      , .rise(r1), .fall(f1)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #2;
      end
   endtask

   // Model: o flips once the last FILT_CNT synchronised samples all differ
   // from it; an aborted run (sample returns to o without a flip) sets glitch.
   int fc[2] = '{8, 1};
   bit mdly [2][4][SS];
   bit mwin [2][4][256];
   bit mo   [2][4];
   bit mg   [2][4];
   bit mr   [2][4];
   bit mf   [2][4];
   bit mtog [2][4];

   task automatic model_step();
      bit s, alld, gset;
      logic [3:0] iv;
      for (int m = 0; m < 2; m++) begin
         iv = (m == 0) ? i0 : i1;
         for (int c = 0; c < 4; c++) begin
            if (!RSTB) begin
               for (int k = 0; k < SS; k++) mdly[m][c][k] = 1'b0;
               for (int k = 0; k < 256; k++) mwin[m][c][k] = 1'b0;
               mo[m][c] = 1'b0; mg[m][c] = 1'b0; mr[m][c] = 1'b0;
               mf[m][c] = 1'b0; mtog[m][c] = 1'b0;
            end else begin
               s = mdly[m][c][SS-1];
               for (int k = SS-1; k > 0; k--) mdly[m][c][k] = mdly[m][c][k-1];
               mdly[m][c][0] = iv[c];
               for (int k = 255; k > 0; k--) mwin[m][c][k] = mwin[m][c][k-1];
               mwin[m][c][0] = s;
               alld = 1'b1;
               for (int k = 0; k < fc[m]; k++)
                  if (mwin[m][c][k] == mo[m][c]) alld = 1'b0;
               gset = (s == mo[m][c]) && (mwin[m][c][1] != mo[m][c]) && !mtog[m][c];
               mr[m][c]   = alld && !mo[m][c];
               mf[m][c]   = alld && mo[m][c];
               mtog[m][c] = alld;
               if (alld) mo[m][c] = !mo[m][c];
               mg[m][c] = gset || (mg[m][c] && !glitch_clr);
            end
         end
      end
   endtask

   initial forever begin
      @(posedge CLK);
      model_step();
   end

   initial forever begin
      logic [3:0] eo, eg, er, ef, ao, ag;
      @(negedge CLK);
      if (chk_en) begin
         for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) begin
               eo[c] = RSTB ? mo[m][c] : 1'b0;
               eg[c] = RSTB ? mg[m][c] : 1'b0;
               er[c] = RSTB ? mr[m][c] : 1'b0;
               ef[c] = RSTB ? mf[m][c] : 1'b0;
            end
            ao = (m == 0) ? o0 : o1;
            ag = (m == 0) ? g0 : g1;
            chk($sformatf("model_o[dut%0d]", m), int'(ao), int'(eo));
            chk($sformatf("model_glitch[dut%0d]", m), int'(ag), int'(eg));
`ifdef DBUF_FILT_EDGE_EN
            chk($sformatf("model_rise[dut%0d]", m), int'((m == 0) ? r0 : r1), int'(er));
            chk($sformatf("model_fall[dut%0d]", m), int'((m == 0) ? f0 : f1), int'(ef));
`endif
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int dur[4];
      int rise_e[4];
      int fall_e[4];

      tick(3);
      chk_en = 1'b1;
      tick(2);
      RSTB = 1'b1;

      // reset state, inputs idle
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("idle_o", int'(o0), 0);
         chk("idle_glitch", int'(g0), 0);
      end

      // step on channel 0: 2 sync + 8 filter edges
      i0[0] = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!o0[0] && n < 40);
      chk("step_latency", n, 10);
`ifdef DBUF_FILT_EDGE_EN
      chk("step_rise_on", int'(r0[0]), 1);
      tick();
      chk("step_rise_off", int'(r0[0]), 0);
`endif
      chk("step_others", int'(o0[3:1]), 0);

      // 5-cycle pulse on channel 1 is filtered and flagged
      i0[1] = 1'b1;
      tick(5);
      i0[1] = 1'b0;
      tick(15);
      chk("pulse_o1", int'(o0[1]), 0);
      chk("pulse_glitch1", int'(g0[1]), 1);

      // clear coincides with a new glitch on channel 2: set wins there
      i0[2] = 1'b1;
      tick(3);
      i0[2] = 1'b0;
      tick(2);
      glitch_clr = 1'b1;
      tick();
      glitch_clr = 1'b0;
      chk("clr_glitch1", int'(g0[1]), 0);
      chk("clr_set_wins2", int'(g0[2]), 1);
      chk("clr_o2", int'(o0[2]), 0);
      glitch_clr = 1'b1;
      tick();
      glitch_clr = 1'b0;
      chk("clr_all", int'(g0), 0);

      // FILT_CNT=1 instance: 2 sync + 1 filter edge, no glitches
      i1[2] = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!o1[2] && n < 40);
      chk("f1_rise_latency", n, 3);
      i1[2] = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (o1[2] && n < 40);
      chk("f1_fall_latency", n, 3);
      i1[1] = 1'b1;
      tick();
      i1[1] = 1'b0;
      tick(6);
      chk("f1_no_glitch", int'(g1), 0);

      // reset while channel 3 sits at cnt=4
      i0[3] = 1'b1;
      tick(6);
      RSTB = 1'b0;
      #1;
      chk("rst_o", int'(o0), 0);
      chk("rst_glitch", int'(g0), 0);
      i0 = 4'h0;
      i1 = 4'h0;
      tick(2);
      RSTB = 1'b1;
      tick(20);
      chk("rst_no_transition", int'(o0[3]), 0);
      chk("rst_no_glitch", int'(g0), 0);

      // staggered pulses on all channels
      dur = '{3, 8, 12, 20};
      for (int c = 0; c < 4; c++) begin
         rise_e[c] = -1;
         fall_e[c] = -1;
      end
      i0 = 4'hf;
      for (int e = 1; e <= 40; e++) begin
         tick();
         for (int c = 0; c < 4; c++) begin
            if (o0[c] && rise_e[c] < 0) rise_e[c] = e;
            if (rise_e[c] >= 0 && !o0[c] && fall_e[c] < 0) fall_e[c] = e;
            if (e == dur[c]) i0[c] = 1'b0;
         end
      end
      chk("stag_rise0", rise_e[0], -1);
      chk("stag_rise1", rise_e[1], 10);
      chk("stag_rise2", rise_e[2], 10);
      chk("stag_rise3", rise_e[3], 10);
      chk("stag_fall1", fall_e[1], 18);
      chk("stag_fall2", fall_e[2], 22);
      chk("stag_fall3", fall_e[3], 30);
      chk("stag_glitch", int'(g0), 1);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
